// File: rtl/spi_flash_boot_loader.sv
// Boot copy engine: reads BOOT_WORDS words from SPI flash with READ (0x03) and
// writes them to SRAM, holding the CPU in reset until the copy has finished.
//
// state    | meaning
// IDLE     | waiting for start_i
// CS_SETUP | CS low, first MOSI bit driven, CLK_DIV setup clocks
// CMD      | shifting out the 0x03 opcode
// ADDR     | shifting out the 24-bit flash address
// DATA     | shifting in four bytes of the next word
// WRITE    | SRAM write request held until granted, SCK parked low
// CS_HOLD  | CLK_DIV hold clocks before CS is released
// DONE     | copy complete, CPU released; terminal
module spi_flash_boot_loader #(
  parameter int unsigned CLK_DIV    = 2,
  parameter logic [23:0] FLASH_BASE = 24'h000000,
  parameter int unsigned SRAM_BASE  = 0,
  parameter int unsigned BOOT_WORDS = 1024,
  parameter int unsigned ADDR_W     = 12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              cpu_rst_no,
  output logic              spi_sck_o,
  output logic              spi_cs_no,
  output logic              spi_mosi_o,
  input  logic              spi_miso_i,
  output logic              wp_no,
  output logic              hold_no,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_be_o,
  input  logic              mem_gnt_i
);

  typedef enum logic [2:0] {
    IDLE, CS_SETUP, CMD, ADDR, DATA, WRITE, CS_HOLD, DONE
  } state_t;

  localparam int unsigned       DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LOAD  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
  localparam logic [31:0]       TX_INIT   = {8'h03, FLASH_BASE};
  localparam logic [ADDR_W:0]   WC_LAST   = (ADDR_W+1)'((BOOT_WORDS == 0) ? 0 : BOOT_WORDS - 1);
  localparam logic [ADDR_W:0]   WC_ONE    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(SRAM_BASE);

  state_t            state, state_d;
  logic [DIV_W-1:0]  div_cnt;
  logic              sck, mosi;
  logic [30:0]       tx_sr;
  logic [7:0]        rx_sr;
  logic [31:0]       wdata;
  logic [4:0]        bit_cnt;
  logic [1:0]        byte_cnt;
  logic [ADDR_W:0]   word_count;
  logic              tick, sck_on, sck_rise, sck_fall, bit_last, word_last, div_run;

  always_comb begin
    tick      = (div_cnt == '0);
    sck_on    = (state == CMD) || (state == ADDR) || (state == DATA);
    div_run   = sck_on || (state == CS_SETUP) || (state == CS_HOLD);
    sck_rise  = sck_on && tick && !sck;
    sck_fall  = sck_on && tick && sck;
    word_last = (word_count == WC_LAST);
    bit_last  = (bit_cnt == 5'd7);
    if (state == ADDR) bit_last = (bit_cnt == 5'd23);

    state_d = state;
    case (state)
      IDLE: begin
        if (start_i) begin
          if (BOOT_WORDS == 0) state_d = DONE;
          else                 state_d = CS_SETUP;
        end
      end
      CS_SETUP: if (tick) state_d = CMD;
      CMD:      if (sck_fall && bit_last) state_d = ADDR;
      ADDR:     if (sck_fall && bit_last) state_d = DATA;
      DATA:     if (sck_fall && bit_last && (byte_cnt == 2'd3)) state_d = WRITE;
      WRITE: begin
        if (mem_gnt_i) begin
          if (word_last) state_d = CS_HOLD;
          else           state_d = DATA;
        end
      end
      CS_HOLD:  if (tick) state_d = DONE;
      default:  state_d = DONE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt    <= DIV_LOAD;
      sck        <= 1'b0;
      mosi       <= 1'b0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      wdata      <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      word_count <= '0;
    end else begin
      // Divider restarts on every phase change so each phase begins with a full half-period.
      if (!div_run || tick || (state_d != state)) div_cnt <= DIV_LOAD;
      else                                        div_cnt <= div_cnt - DIV_ONE;

      case (state)
        IDLE: begin
          if (state_d == CS_SETUP) begin
            tx_sr      <= TX_INIT[30:0];
            mosi       <= TX_INIT[31];
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            word_count <= '0;
          end
        end
        CMD, ADDR: begin
          if (tick) sck <= !sck;
          if (sck_fall) begin
            mosi    <= tx_sr[30];
            tx_sr   <= {tx_sr[29:0], 1'b0};
            bit_cnt <= bit_last ? '0 : bit_cnt + 5'd1;
          end
        end
        DATA: begin
          mosi <= 1'b0;
          if (tick) sck <= !sck;
          if (sck_rise) rx_sr <= {rx_sr[6:0], spi_miso_i};
          if (sck_fall) begin
            bit_cnt <= bit_last ? '0 : bit_cnt + 5'd1;
            if (bit_last) begin
              byte_cnt <= byte_cnt + 2'd1;
              wdata    <= {rx_sr, wdata[31:8]};
            end
          end
        end
        WRITE: begin
          if (mem_gnt_i) word_count <= word_count + WC_ONE;
        end
        default: sck <= 1'b0;
      endcase
    end
  end

  assign busy_o      = (state != IDLE) && (state != DONE);
  assign done_o      = (state == DONE);
  assign cpu_rst_no  = done_o;
  assign spi_cs_no   = !busy_o;
  assign spi_sck_o   = sck;
  assign spi_mosi_o  = mosi;
  assign wp_no       = 1'b1;
  assign hold_no     = 1'b1;
  assign mem_req_o   = (state == WRITE);
  assign mem_we_o    = mem_req_o;
  assign mem_addr_o  = ADDR_BASE + word_count[ADDR_W-1:0];
  assign mem_wdata_o = wdata;
  assign mem_be_o    = 4'hF;

endmodule

// File: tb/tb_spi_flash_boot_loader.sv
// Bench for spi_flash_boot_loader: flash models on three instances, scoreboard of SRAM writes.
`timescale 1ns/1ps
module tb_spi_flash_boot_loader;
  localparam int A_WORDS = 4;
  localparam int B_WORDS = 2;
  localparam logic [23:0] B_BASE = 24'h123456;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // instance a: CLK_DIV=2, 4 words, flash base 0
  logic a_rst_n = 1'b0, a_start = 1'b0, a_miso = 1'b0, a_gnt = 1'b1;
  logic a_busy, a_done, a_cpu_rst_n, a_sck, a_cs_n, a_mosi, a_wp_n, a_hold_n, a_req, a_we;
  logic [11:0] a_addr;
  logic [31:0] a_wdata;
  logic [3:0]  a_be;
  // instance z: zero words
  logic z_rst_n = 1'b0, z_start = 1'b0, z_miso = 1'b0, z_gnt = 1'b1;
  logic z_busy, z_done, z_cpu_rst_n, z_sck, z_cs_n, z_mosi, z_wp_n, z_hold_n, z_req, z_we;
  logic [11:0] z_addr;
  logic [31:0] z_wdata;
  logic [3:0]  z_be;
  // instance b: CLK_DIV=1, 2 words, flash base 0x123456
  logic b_rst_n = 1'b0, b_start = 1'b0, b_miso = 1'b0, b_gnt = 1'b1;
  logic b_busy, b_done, b_cpu_rst_n, b_sck, b_cs_n, b_mosi, b_wp_n, b_hold_n, b_req, b_we;
  logic [11:0] b_addr;
  logic [31:0] b_wdata;
  logic [3:0]  b_be;

  spi_flash_boot_loader #(.CLK_DIV(2), .FLASH_BASE(24'h000000), .SRAM_BASE(0), .BOOT_WORDS(A_WORDS), .ADDR_W(12)) dut_a (
    .clk_i(clk), .rst_ni(a_rst_n), .start_i(a_start), .busy_o(a_busy), .done_o(a_done),
    .cpu_rst_no(a_cpu_rst_n), .spi_sck_o(a_sck), .spi_cs_no(a_cs_n), .spi_mosi_o(a_mosi),
    .spi_miso_i(a_miso), .wp_no(a_wp_n), .hold_no(a_hold_n), .mem_req_o(a_req), .mem_we_o(a_we),
    .mem_addr_o(a_addr), .mem_wdata_o(a_wdata), .mem_be_o(a_be), .mem_gnt_i(a_gnt));

  spi_flash_boot_loader #(.CLK_DIV(2), .FLASH_BASE(24'h000000), .SRAM_BASE(0), .BOOT_WORDS(0), .ADDR_W(12)) dut_z (
    .clk_i(clk), .rst_ni(z_rst_n), .start_i(z_start), .busy_o(z_busy), .done_o(z_done),
    .cpu_rst_no(z_cpu_rst_n), .spi_sck_o(z_sck), .spi_cs_no(z_cs_n), .spi_mosi_o(z_mosi),
    .spi_miso_i(z_miso), .wp_no(z_wp_n), .hold_no(z_hold_n), .mem_req_o(z_req), .mem_we_o(z_we),
    .mem_addr_o(z_addr), .mem_wdata_o(z_wdata), .mem_be_o(z_be), .mem_gnt_i(z_gnt));

  spi_flash_boot_loader #(.CLK_DIV(1), .FLASH_BASE(B_BASE), .SRAM_BASE(0), .BOOT_WORDS(B_WORDS), .ADDR_W(12)) dut_b (
    .clk_i(clk), .rst_ni(b_rst_n), .start_i(b_start), .busy_o(b_busy), .done_o(b_done),
    .cpu_rst_no(b_cpu_rst_n), .spi_sck_o(b_sck), .spi_cs_no(b_cs_n), .spi_mosi_o(b_mosi),
    .spi_miso_i(b_miso), .wp_no(b_wp_n), .hold_no(b_hold_n), .mem_req_o(b_req), .mem_we_o(b_we),
    .mem_addr_o(b_addr), .mem_wdata_o(b_wdata), .mem_be_o(b_be), .mem_gnt_i(b_gnt));

  // Flash content: every byte equals the low byte of its own address.
  function automatic logic flash_bit(input logic [23:0] base, input int k);
    logic [23:0] a;
    logic [7:0]  b;
    a = base + 24'(k / 8);
    b = a[7:0];
    return b[7 - (k % 8)];
  endfunction

  function automatic logic [31:0] exp_word(input logic [23:0] base, input int w);
    logic [31:0] d;
    logic [23:0] a;
    d = '0;
    for (int j = 0; j < 4; j++) begin
      a = base + 24'(4 * w + j);
      d[8*j +: 8] = a[7:0];
    end
    return d;
  endfunction

  // Flash models: capture command on SCK rise, drive MISO on SCK fall.
  logic [31:0] a_cmd = '0, b_cmd = '0;
  int a_rises = 0, a_dbits = 0, a_sck_cnt = 0;
  int b_rises = 0, b_dbits = 0, b_sck_cnt = 0, b_period_err = 0;
  time b_last_rise = 0;

  always @(posedge a_sck or negedge a_sck or posedge a_cs_n) begin
    if (a_cs_n !== 1'b0) begin
      a_rises = 0; a_dbits = 0;
    end else if (a_sck === 1'b1) begin
      if (a_rises < 32) a_cmd = {a_cmd[30:0], a_mosi};
      a_rises++; a_sck_cnt++;
    end else if (a_rises >= 32) begin
      a_miso = flash_bit(a_cmd[23:0], a_dbits); a_dbits++;
    end
  end

  always @(posedge b_sck or negedge b_sck or posedge b_cs_n) begin
    if (b_cs_n !== 1'b0) begin
      b_rises = 0; b_dbits = 0;
    end else if (b_sck === 1'b1) begin
      if (b_rises >= 1 && b_rises < 32 && ($time - b_last_rise) != 20) b_period_err++;
      b_last_rise = $time;
      if (b_rises < 32) b_cmd = {b_cmd[30:0], b_mosi};
      b_rises++; b_sck_cnt++;
    end else begin
      if (b_rises >= 1 && b_rises <= 32 && ($time - b_last_rise) != 10) b_period_err++;
      if (b_rises >= 32) begin
        b_miso = flash_bit(b_cmd[23:0], b_dbits); b_dbits++;
      end
    end
  end

  // SRAM side: grant generator and write monitor, all on the falling clock edge.
  int a_gnt_delay = 0;
  int a_wait = 0, a_nobs = 0, a_stab_err = 0, a_sck_req_err = 0, a_req_cycles = 0;
  logic [11:0] a_obs_addr[$];
  logic [31:0] a_obs_data[$];
  logic a_prev_req = 1'b0;
  logic [11:0] a_prev_addr = '0;
  logic [31:0] a_prev_data = '0;

  always @(negedge clk) begin
    if (a_req === 1'b1) begin
      if (a_prev_req && (a_addr !== a_prev_addr || a_wdata !== a_prev_data)) a_stab_err++;
      if (a_sck !== 1'b0) a_sck_req_err++;
      a_req_cycles++;
      a_gnt = (a_wait >= a_gnt_delay);
      a_wait++;
      if (a_gnt) begin
        a_obs_addr.push_back(a_addr); a_obs_data.push_back(a_wdata); a_nobs++;
      end
    end else begin
      a_wait = 0;
      a_gnt = (a_gnt_delay == 0);
    end
    a_prev_req  = (a_req === 1'b1) && !a_gnt;
    a_prev_addr = a_addr;
    a_prev_data = a_wdata;
  end

  int b_nobs = 0;
  logic [11:0] b_obs_addr[$];
  logic [31:0] b_obs_data[$];
  int z_cs_low = 0, z_req_cnt = 0;

  always @(negedge clk) begin
    if (b_req === 1'b1 && b_gnt) begin
      b_obs_addr.push_back(b_addr); b_obs_data.push_back(b_wdata); b_nobs++;
    end
    if (z_cs_n === 1'b0) z_cs_low++;
    if (z_req === 1'b1) z_req_cnt++;
  end

  // Scoreboard of expected SRAM writes for instance a.
  logic [11:0] a_exp_addr[$];
  logic [31:0] a_exp_data[$];

  task automatic push_a_expected();
    a_exp_addr.delete(); a_exp_data.delete();
    for (int i = 0; i < A_WORDS; i++) begin
      a_exp_addr.push_back(12'(i));
      a_exp_data.push_back(exp_word(24'h0, i));
    end
  endtask

  task automatic reset_a();
    @(negedge clk); a_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    a_rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_a_start();
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
  endtask

  task automatic wait_a_done(output int n);
    n = 0;
    while (a_done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({a_busy, a_done, a_cpu_rst_n, a_sck, a_cs_n, a_mosi, a_req, a_we} !== 8'b0000_1000) begin
      errors++; $display("FAIL reset_ctrl: busy/done/cpu_rst_n/sck/cs_n/mosi/req/we=%b required 00001000",
                         {a_busy, a_done, a_cpu_rst_n, a_sck, a_cs_n, a_mosi, a_req, a_we});
    end
    checks++;
    if (a_addr !== 12'h000 || a_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_mem: addr=%h wdata=%h required 000 00000000", a_addr, a_wdata);
    end
    checks++;
    if ({a_wp_n, a_hold_n, a_be} !== 6'b11_1111) begin
      errors++; $display("FAIL reset_const: wp_n/hold_n/be=%b required 111111", {a_wp_n, a_hold_n, a_be});
    end
    checks++;
    if ({z_cs_n, z_done, b_cs_n, b_done} !== 4'b1010) begin
      errors++; $display("FAIL reset_others: z_cs_n/z_done/b_cs_n/b_done=%b required 1010", {z_cs_n, z_done, b_cs_n, b_done});
    end
    a_rst_n = 1'b1; z_rst_n = 1'b1; b_rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_copy(input int delay, input string tag);
    int n, n0, s0, e0, r0, q0;
    logic [11:0] ea;
    logic [31:0] ed;
    reset_a();
    a_gnt_delay = delay;
    n0 = a_nobs; s0 = a_sck_cnt; e0 = a_stab_err + a_sck_req_err; r0 = a_req_cycles;
    push_a_expected();
    pulse_a_start();
    checks++;
    if ({a_busy, a_cpu_rst_n, a_cs_n, a_done} !== 4'b1000) begin
      errors++; $display("FAIL %s_running: busy/cpu_rst_n/cs_n/done=%b required 1000", tag, {a_busy, a_cpu_rst_n, a_cs_n, a_done});
    end
    wait_a_done(n);
    checks++;
    if ({a_done, a_cpu_rst_n, a_busy, a_cs_n} !== 4'b1101) begin
      errors++; $display("FAIL %s_done: done/cpu_rst_n/busy/cs_n=%b required 1101 (waited %0d)", tag, {a_done, a_cpu_rst_n, a_busy, a_cs_n}, n);
    end
    checks++;
    if (a_cmd !== 32'h0300_0000) begin
      errors++; $display("FAIL %s_mosi: command+address=%h required 03000000", tag, a_cmd);
    end
    for (int i = 0; i < A_WORDS; i++) begin
      ea = a_exp_addr.pop_front(); ed = a_exp_data.pop_front();
      checks++;
      if (a_nobs <= n0 + i) begin
        errors++; $display("FAIL %s_write%0d: no write seen, required addr %h data %h", tag, i, ea, ed);
      end else if (a_obs_addr[n0+i] !== ea || a_obs_data[n0+i] !== ed) begin
        errors++; $display("FAIL %s_write%0d: addr %h data %h, required addr %h data %h", tag, i, a_obs_addr[n0+i], a_obs_data[n0+i], ea, ed);
      end
    end
    checks++;
    if (a_nobs - n0 != A_WORDS) begin
      errors++; $display("FAIL %s_count: %0d writes, required %0d", tag, a_nobs - n0, A_WORDS);
    end
    checks++;
    if (a_sck_cnt - s0 != 160) begin
      errors++; $display("FAIL %s_sck: %0d SCK rises, required 160", tag, a_sck_cnt - s0);
    end
    q0 = a_req_cycles - r0;
    checks++;
    if (q0 != A_WORDS * (delay + 1)) begin
      errors++; $display("FAIL %s_req_cycles: req high %0d cycles, required %0d", tag, q0, A_WORDS * (delay + 1));
    end
    checks++;
    if (a_stab_err + a_sck_req_err != e0) begin
      errors++; $display("FAIL %s_stall: %0d stall violations (unstable addr/wdata or SCK high), required 0", tag, a_stab_err + a_sck_req_err - e0);
    end
  endtask

  task automatic test_reset_midway();
    int n, k, n0;
    logic [11:0] ea;
    logic [31:0] ed;
    reset_a();
    a_gnt_delay = 0;
    n0 = a_nobs;
    push_a_expected();
    pulse_a_start();
    k = 0;
    while (a_nobs < n0 + 2 && k < 2000) begin @(negedge clk); k++; end
    checks++;
    if (a_nobs < n0 + 2) begin
      errors++; $display("FAIL midrst_progress: %0d writes before timeout, required 2", a_nobs - n0);
    end
    for (int i = 0; i < 2; i++) begin
      ea = a_exp_addr.pop_front(); ed = a_exp_data.pop_front();
      checks++;
      if (a_obs_addr[n0+i] !== ea || a_obs_data[n0+i] !== ed) begin
        errors++; $display("FAIL midrst_write%0d: addr %h data %h, required addr %h data %h", i, a_obs_addr[n0+i], a_obs_data[n0+i], ea, ed);
      end
    end
    repeat (20) @(negedge clk);
    #2 a_rst_n = 1'b0;
    #1;
    checks++;
    if ({a_cs_n, a_sck, a_done, a_busy, a_req, a_cpu_rst_n} !== 6'b100000) begin
      errors++; $display("FAIL midrst_state: cs_n/sck/done/busy/req/cpu_rst_n=%b required 100000", {a_cs_n, a_sck, a_done, a_busy, a_req, a_cpu_rst_n});
    end
    repeat (3) @(negedge clk);
    a_rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if ({a_cs_n, a_done, a_nobs - n0 == 2} !== 3'b101) begin
      errors++; $display("FAIL midrst_idle: cs_n=%b done=%b writes=%0d, required cs_n 1 done 0 writes 2", a_cs_n, a_done, a_nobs - n0);
    end
    n0 = a_nobs;
    push_a_expected();
    pulse_a_start();
    wait_a_done(n);
    checks++;
    if (a_done !== 1'b1 || a_cmd !== 32'h0300_0000) begin
      errors++; $display("FAIL midrst_restart: done=%b cmd=%h, required done 1 cmd 03000000", a_done, a_cmd);
    end
    for (int i = 0; i < A_WORDS; i++) begin
      ea = a_exp_addr.pop_front(); ed = a_exp_data.pop_front();
      checks++;
      if (a_nobs <= n0 + i || a_obs_addr[n0+i] !== ea || a_obs_data[n0+i] !== ed) begin
        errors++; $display("FAIL midrst_rewrite%0d: writes=%0d, required addr %h data %h", i, a_nobs - n0, ea, ed);
      end
    end
  endtask

  task automatic test_start_ignored();
    int n, n0, s0;
    logic [11:0] ea;
    logic [31:0] ed;
    reset_a();
    a_gnt_delay = 0;
    n0 = a_nobs;
    push_a_expected();
    pulse_a_start();
    repeat (200) @(negedge clk);
    pulse_a_start();
    wait_a_done(n);
    for (int i = 0; i < A_WORDS; i++) begin
      ea = a_exp_addr.pop_front(); ed = a_exp_data.pop_front();
      checks++;
      if (a_nobs <= n0 + i || a_obs_addr[n0+i] !== ea || a_obs_data[n0+i] !== ed) begin
        errors++; $display("FAIL ignore_write%0d: writes=%0d, required addr %h data %h", i, a_nobs - n0, ea, ed);
      end
    end
    s0 = a_sck_cnt;
    pulse_a_start();
    repeat (60) @(negedge clk);
    checks++;
    if (a_nobs - n0 != A_WORDS || a_sck_cnt != s0) begin
      errors++; $display("FAIL ignore_after_done: writes=%0d extra_sck=%0d, required %0d and 0", a_nobs - n0, a_sck_cnt - s0, A_WORDS);
    end
    checks++;
    if ({a_done, a_cpu_rst_n, a_cs_n, a_busy} !== 4'b1110) begin
      errors++; $display("FAIL ignore_state: done/cpu_rst_n/cs_n/busy=%b required 1110", {a_done, a_cpu_rst_n, a_cs_n, a_busy});
    end
  endtask

  task automatic test_zero_words();
    @(negedge clk);
    checks++;
    if (z_done !== 1'b0) begin
      errors++; $display("FAIL zero_pre: done=%b required 0", z_done);
    end
    z_start = 1'b1;
    @(negedge clk); z_start = 1'b0;
    checks++;
    if ({z_done, z_cpu_rst_n, z_busy} !== 3'b110) begin
      errors++; $display("FAIL zero_done: done/cpu_rst_n/busy=%b one cycle after start, required 110", {z_done, z_cpu_rst_n, z_busy});
    end
    repeat (20) @(negedge clk);
    checks++;
    if (z_cs_low != 0 || z_req_cnt != 0 || z_done !== 1'b1) begin
      errors++; $display("FAIL zero_bus: cs low %0d cycles, req %0d cycles, done=%b, required 0 0 1", z_cs_low, z_req_cnt, z_done);
    end
  endtask

  task automatic test_fast_base();
    int k;
    logic [31:0] ed;
    b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    k = 0;
    while (b_done !== 1'b1 && k < 2000) begin @(negedge clk); k++; end
    checks++;
    if (b_done !== 1'b1 || b_cs_n !== 1'b1) begin
      errors++; $display("FAIL fast_done: done=%b cs_n=%b after %0d cycles, required 1 1", b_done, b_cs_n, k);
    end
    checks++;
    if (b_cmd !== {8'h03, B_BASE}) begin
      errors++; $display("FAIL fast_mosi: command+address=%h required %h", b_cmd, {8'h03, B_BASE});
    end
    checks++;
    if (b_period_err != 0 || b_sck_cnt != 32 + 32 * B_WORDS) begin
      errors++; $display("FAIL fast_sck: %0d timing errors, %0d rises, required 0 and %0d", b_period_err, b_sck_cnt, 32 + 32 * B_WORDS);
    end
    for (int i = 0; i < B_WORDS; i++) begin
      ed = exp_word(B_BASE, i);
      checks++;
      if (b_nobs <= i || b_obs_addr[i] !== 12'(i) || b_obs_data[i] !== ed) begin
        errors++; $display("FAIL fast_write%0d: writes=%0d, required addr %h data %h", i, b_nobs, 12'(i), ed);
      end
    end
  endtask

  initial begin
    test_reset();
    test_copy(0, "copy");
    test_copy(5, "stall");
    test_reset_midway();
    test_start_ignored();
    test_zero_words();
    test_fast_base();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
